// File: rtl/special_mem_sequencer.sv
// Sequencer for the special MEM-stage ops (LWi / SWi / Add): each op is a
// read-then-read or read-then-write pair on the data port, followed by a one-cycle done pulse.
module special_mem_sequencer (
    input  logic        clk,
    input  logic        rest,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic        LWi,
    output logic        SWi,
    output logic        Add,
    output logic [31:0] result,
    output logic        done
);
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SW   = 2'd1;
    localparam logic [1:0] OP_LW   = 2'd2;
    localparam logic [1:0] OP_NONE = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] ptr_q, ptr_d;
    logic [31:0] sum_q, sum_d;
    logic [31:0] result_q, result_d;
    logic        in_seq;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state_q  <= IDLE;
            op_q     <= 2'd0;
            addr_q   <= 32'd0;
            wd_q     <= 32'd0;
            ptr_q    <= 32'd0;
            sum_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wd_q     <= wd_d;
            ptr_q    <= ptr_d;
            sum_q    <= sum_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        ptr_d     = ptr_q;
        sum_d     = sum_q;
        result_d  = result_q;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && op != OP_NONE) begin
                    op_d    = op;
                    addr_d  = addr;
                    wd_d    = wdata;
                    state_d = RD1;
                end
            end
            RD1: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                if (mem_ready) begin
                    if (op_q == OP_ADD) begin
                        sum_d   = mem_rdata + wd_q;
                        state_d = WR;
                    end else begin
                        ptr_d   = mem_rdata;
                        state_d = (op_q == OP_LW) ? RD2 : WR;
                    end
                end
            end
            RD2: begin
                mem_read = 1'b1;
                mem_addr = ptr_q;
                if (mem_ready) begin
                    result_d = mem_rdata;
                    state_d  = DONE;
                end
            end
            WR: begin
                // SWi stores the operand through the pointer; Add writes the sum back in place.
                mem_write = 1'b1;
                mem_addr  = (op_q == OP_SW) ? ptr_q : addr_q;
                mem_wdata = (op_q == OP_SW) ? wd_q : sum_q;
                if (mem_ready) begin
                    if (op_q == OP_ADD) result_d = sum_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_seq = (state_q == RD1) || (state_q == RD2) || (state_q == WR);
    assign LWi    = in_seq && (op_q == OP_LW);
    assign SWi    = in_seq && (op_q == OP_SW);
    assign Add    = in_seq && (op_q == OP_ADD);
    assign result = result_q;
endmodule
